// File: rtl/alu_issue_ctrl.sv
// ---------------------------------------------------------------------------
// alu_issue_ctrl
// Multi-cycle issue controller for the 16-bit combinational ALU. Accepts one
// register-to-register operation per handshake, reads both operands from an
// internal NREG x W register file, presents them to the ALU, captures the
// result and writes it back to the destination (ri). Also owns the compare
// flag, derived from the ALU zero output (zero LOW means operands equal).
//
// Ports:
//   clk, rst_n         clock / asynchronous active-low reset
//   i_instr_valid      upstream op present
//   o_instr_ready      controller can accept an op (IDLE and no load)
//   i_instr_func       ALU function code (111 is illegal)
//   i_instr_ri/rj      first operand + destination / second operand index
//   i_ld_en/addr/data  direct register load strobe, index and value
//   o_alu_ri/rj/func   registered operands and function code to the ALU
//   i_alu_out          ALU result
//   i_alu_zero         ALU compare output, LOW when ri == rj
//   o_done             one-cycle pulse at op completion
//   o_eq_flag          operands of the last cmp/sub were equal
//   o_err              one-cycle pulse on an illegal function code
//   i_dbg_addr         debug read index
//   o_dbg_data         combinational register file read
// ---------------------------------------------------------------------------
module alu_issue_ctrl #(
    parameter int W    = 16,
    parameter int NREG = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_instr_valid,
    output logic                    o_instr_ready,
    input  logic [2:0]              i_instr_func,
    input  logic [$clog2(NREG)-1:0] i_instr_ri,
    input  logic [$clog2(NREG)-1:0] i_instr_rj,
    input  logic                    i_ld_en,
    input  logic [$clog2(NREG)-1:0] i_ld_addr,
    input  logic [W-1:0]            i_ld_data,
    output logic [W-1:0]            o_alu_ri,
    output logic [W-1:0]            o_alu_rj,
    output logic [2:0]              o_alu_func,
    input  logic [W-1:0]            i_alu_out,
    input  logic                    i_alu_zero,
    output logic                    o_done,
    output logic                    o_eq_flag,
    output logic                    o_err,
    input  logic [$clog2(NREG)-1:0] i_dbg_addr,
    output logic [W-1:0]            o_dbg_data
);

    localparam int AW = $clog2(NREG);

    localparam logic [2:0] FN_SUB     = 3'b010;
    localparam logic [2:0] FN_CMP     = 3'b110;
    localparam logic [2:0] FN_ILLEGAL = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_EXEC  = 2'd2,
        S_WB    = 2'd3
    } state_t;

    state_t          r_state;
    logic [W-1:0]    r_regs [NREG];
    logic [2:0]      r_func;
    logic [AW-1:0]   r_ri;
    logic [AW-1:0]   r_rj;
    logic [W-1:0]    r_res;
    logic            r_eqs;
    logic [W-1:0]    r_alu_ri;
    logic [W-1:0]    r_alu_rj;
    logic [2:0]      r_alu_func;
    logic            r_done;
    logic            r_err;
    logic            r_eq_flag;

    // A pending load blocks issue so the load always wins the edge.
    assign o_instr_ready = (r_state == S_IDLE) && !i_ld_en;

    assign o_alu_ri   = r_alu_ri;
    assign o_alu_rj   = r_alu_rj;
    assign o_alu_func = r_alu_func;
    assign o_done     = r_done;
    assign o_err      = r_err;
    assign o_eq_flag  = r_eq_flag;
    assign o_dbg_data = r_regs[i_dbg_addr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
            r_func     <= '0;
            r_ri       <= '0;
            r_rj       <= '0;
            r_res      <= '0;
            r_eqs      <= 1'b0;
            r_alu_ri   <= '0;
            r_alu_rj   <= '0;
            r_alu_func <= '0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_eq_flag  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_ld_en) begin
                        r_regs[i_ld_addr] <= i_ld_data;
                    end else if (i_instr_valid) begin
                        // Illegal ops are consumed in place: no fetch, no done.
                        if (i_instr_func == FN_ILLEGAL) begin
                            r_err <= 1'b1;
                        end else begin
                            r_func  <= i_instr_func;
                            r_ri    <= i_instr_ri;
                            r_rj    <= i_instr_rj;
                            r_state <= S_FETCH;
                        end
                    end
                end
                // Operand read: both sources sampled before any writeback,
                // so a destination that is also rj sees its pre-op value.
                S_FETCH: begin
                    r_alu_ri   <= r_regs[r_ri];
                    r_alu_rj   <= r_regs[r_rj];
                    r_alu_func <= r_func;
                    r_state    <= S_EXEC;
                end
                // ALU has had a full cycle to settle on the registered inputs.
                S_EXEC: begin
                    r_res   <= i_alu_out;
                    r_eqs   <= ~i_alu_zero;
                    r_state <= S_WB;
                end
                // Writeback; cmp only updates the flag, sub updates both.
                S_WB: begin
                    if (r_func != FN_CMP) begin
                        r_regs[r_ri] <= r_res;
                    end
                    if ((r_func == FN_CMP) || (r_func == FN_SUB)) begin
                        r_eq_flag <= r_eqs;
                    end
                    r_done  <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// ---------------------------------------------------------------------------
// tb_alu_issue_ctrl
// Self-checking bench for alu_issue_ctrl. Provides a behavioural model of the
// downstream ALU, keeps a reference register file and compare flag, runs the
// directed scenarios followed by randomized loads and operations.
// ---------------------------------------------------------------------------
module tb_alu_issue_ctrl;

    logic        clk;
    logic        rst_n;
    logic        instr_valid;
    logic        instr_ready;
    logic [2:0]  instr_func;
    logic [2:0]  instr_ri;
    logic [2:0]  instr_rj;
    logic        ld_en;
    logic [2:0]  ld_addr;
    logic [15:0] ld_data;
    logic [15:0] alu_ri;
    logic [15:0] alu_rj;
    logic [2:0]  alu_func;
    logic [15:0] alu_out;
    logic        alu_zero;
    logic        done;
    logic        eq_flag;
    logic        err;
    logic [2:0]  dbg_addr;
    logic [15:0] dbg_data;

    int checks = 0;
    int errors = 0;

    logic [15:0] m_regs [8];
    logic        m_eq;

    alu_issue_ctrl #(.W(16), .NREG(8)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_instr_valid (instr_valid),
        .o_instr_ready (instr_ready),
        .i_instr_func  (instr_func),
        .i_instr_ri    (instr_ri),
        .i_instr_rj    (instr_rj),
        .i_ld_en       (ld_en),
        .i_ld_addr     (ld_addr),
        .i_ld_data     (ld_data),
        .o_alu_ri      (alu_ri),
        .o_alu_rj      (alu_rj),
        .o_alu_func    (alu_func),
        .i_alu_out     (alu_out),
        .i_alu_zero    (alu_zero),
        .o_done        (done),
        .o_eq_flag     (eq_flag),
        .o_err         (err),
        .i_dbg_addr    (dbg_addr),
        .o_dbg_data    (dbg_data)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Downstream combinational ALU.
    always_comb begin
        case (alu_func)
            3'd0:    alu_out = alu_rj;
            3'd1:    alu_out = alu_ri + alu_rj;
            3'd2:    alu_out = alu_ri - alu_rj;
            3'd3:    alu_out = alu_ri & alu_rj;
            3'd4:    alu_out = alu_ri | alu_rj;
            3'd5:    alu_out = ~alu_rj;
            default: alu_out = alu_ri - alu_rj;
        endcase
        alu_zero = (alu_ri != alu_rj);
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_regs(input string tag);
        for (int i = 0; i < 8; i++) begin
            dbg_addr = 3'(i);
            #1;
            check($sformatf("%s_r%0d", tag, i), {16'h0, dbg_data}, {16'h0, m_regs[i]});
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_regs[i] = 16'h0;
        m_eq = 1'b0;
    endtask

    task automatic do_ld(input logic [2:0] a, input logic [15:0] d);
        @(negedge clk);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        @(negedge clk);
        ld_en = 1'b0;
        m_regs[a] = d;
    endtask

    // Issue one op (optionally colliding with a load) and check its timeline.
    task automatic run_op(input logic [2:0] f, input logic [2:0] ri, input logic [2:0] rj,
                          input bit with_ld, input logic [2:0] la, input logic [15:0] ldv);
        logic [15:0] a, b, res;
        bit          wr, upd_eq, exp_eq;
        @(negedge clk);
        instr_valid = 1'b1; instr_func = f; instr_ri = ri; instr_rj = rj;
        if (with_ld) begin
            ld_en = 1'b1; ld_addr = la; ld_data = ldv;
            #1;
            check("ready_low_on_load", {31'h0, instr_ready}, 32'h0);
            @(negedge clk);
            ld_en = 1'b0;
            m_regs[la] = ldv;
        end
        #1;
        check("ready_before_accept", {31'h0, instr_ready}, 32'h1);
        // Expected outcome from the pre-op register contents.
        a = m_regs[ri]; b = m_regs[rj];
        wr = 1'b1; upd_eq = 1'b0; res = 16'h0;
        case (f)
            3'd0: res = b;
            3'd1: res = a + b;
            3'd2: begin res = a - b; upd_eq = 1'b1; end
            3'd3: res = a & b;
            3'd4: res = a | b;
            3'd5: res = ~b;
            3'd6: begin wr = 1'b0; upd_eq = 1'b1; end
            default: wr = 1'b0;
        endcase
        exp_eq = (a == b);
        @(posedge clk);
        #1 instr_valid = 1'b0;
        @(negedge clk);
        check("err_after_accept", {31'h0, err}, {31'h0, (f == 3'd7)});
        check("done_after_accept", {31'h0, done}, 32'h0);
        if (f == 3'd7) begin
            check("ready_after_illegal", {31'h0, instr_ready}, 32'h1);
            @(negedge clk);
            check("err_pulse_end", {31'h0, err}, 32'h0);
            check("done_after_illegal", {31'h0, done}, 32'h0);
            check("eq_after_illegal", {31'h0, eq_flag}, {31'h0, m_eq});
            check_regs("illegal");
            return;
        end
        @(negedge clk);
        check("alu_func_fetch", {29'h0, alu_func}, {29'h0, f});
        check("ready_busy", {31'h0, instr_ready}, 32'h0);
        check("done_fetch", {31'h0, done}, 32'h0);
        @(negedge clk);
        check("done_exec", {31'h0, done}, 32'h0);
        @(negedge clk);
        if (wr) m_regs[ri] = res;
        if (upd_eq) m_eq = exp_eq;
        check("done_pulse", {31'h0, done}, 32'h1);
        check("ready_at_done", {31'h0, instr_ready}, 32'h1);
        check("eq_flag", {31'h0, eq_flag}, {31'h0, m_eq});
        check_regs("op");
        @(negedge clk);
        check("done_pulse_end", {31'h0, done}, 32'h0);
    endtask

    initial begin
        rst_n = 1'b0; instr_valid = 1'b0; instr_func = 3'h0; instr_ri = 3'h0;
        instr_rj = 3'h0; ld_en = 1'b0; ld_addr = 3'h0; ld_data = 16'h0; dbg_addr = 3'h0;
        model_reset();
        repeat (2) @(negedge clk);
        check_regs("reset");
        check("reset_ready", {31'h0, instr_ready}, 32'h1);
        check("reset_done", {31'h0, done}, 32'h0);
        check("reset_eq", {31'h0, eq_flag}, 32'h0);
        check("reset_err", {31'h0, err}, 32'h0);
        check("reset_alu_ri", {16'h0, alu_ri}, 32'h0);
        check("reset_alu_func", {29'h0, alu_func}, 32'h0);
        rst_n = 1'b1;

        do_ld(3'd1, 16'h1234);
        do_ld(3'd2, 16'h0F0F);
        run_op(3'd1, 3'd1, 3'd2, 1'b0, 3'd0, 16'h0);
        check("add_r1", {16'h0, m_regs[1]}, 32'h2143);

        do_ld(3'd4, 16'hFFFF);
        do_ld(3'd5, 16'h0001);
        run_op(3'd1, 3'd4, 3'd5, 1'b0, 3'd0, 16'h0);
        run_op(3'd5, 3'd6, 3'd4, 1'b0, 3'd0, 16'h0);

        do_ld(3'd3, 16'h00AA);
        do_ld(3'd7, 16'h00AA);
        run_op(3'd6, 3'd3, 3'd7, 1'b0, 3'd0, 16'h0);
        do_ld(3'd7, 16'h00AB);
        run_op(3'd6, 3'd3, 3'd7, 1'b0, 3'd0, 16'h0);
        run_op(3'd2, 3'd3, 3'd3, 1'b0, 3'd0, 16'h0);

        run_op(3'd7, 3'd1, 3'd2, 1'b0, 3'd0, 16'h0);
        run_op(3'd0, 3'd0, 3'd5, 1'b1, 3'd5, 16'hBEEF);

        // Reset while the add sits in EXEC: no writeback may happen.
        @(negedge clk);
        instr_valid = 1'b1; instr_func = 3'd1; instr_ri = 3'd1; instr_rj = 3'd2;
        @(posedge clk);
        #1 instr_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        #1;
        check("rst_mid_ready", {31'h0, instr_ready}, 32'h1);
        check("rst_mid_done", {31'h0, done}, 32'h0);
        check("rst_mid_eq", {31'h0, eq_flag}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_no_done", {31'h0, done}, 32'h0);
        end
        check_regs("rst_mid");

        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 2) == 0) begin
                do_ld(3'($urandom_range(0, 7)), 16'($urandom));
            end else begin
                run_op(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                       3'($urandom_range(0, 7)), ($urandom_range(0, 4) == 0),
                       3'($urandom_range(0, 7)), 16'($urandom));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
